lstm_function_dot_acc: RTL

LSTM_FUNCTION_DOT_ACC -- requirements
Module: lstm_function_dot_acc

---
 rtl/lstm_function_pkg.sv | 13 +
 rtl/lstm_function_sat_add.sv | 19 +
 rtl/lstm_function_dot_acc.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lstm_function_pkg.sv
// rtl/lstm_function_pkg.sv - shared FSM state and default widths for the LSTM dot-product accumulator
package lstm_function_pkg;

    localparam int DEF_PROD_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_CNT_WIDTH  = 9;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_e;

endpackage

// File: rtl/lstm_function_sat_add.sv
// rtl/lstm_function_sat_add.sv - unsigned saturating adder, narrow operand zero-extended onto the wide one
module lstm_function_sat_add #(
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 16
) (
    input  logic [A_WIDTH-1:0] a_i,
    input  logic [B_WIDTH-1:0] b_i,
    output logic [A_WIDTH-1:0] sum_o,
    output logic               ovf_o
);

    // One extra bit catches the carry that signals saturation.
    logic [A_WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {{(A_WIDTH + 1 - B_WIDTH){1'b0}}, b_i};
    assign ovf_o    = full_sum[A_WIDTH];
    assign sum_o    = ovf_o ? {A_WIDTH{1'b1}} : full_sum[A_WIDTH-1:0];

endmodule

// File: rtl/lstm_function_dot_acc.sv
// rtl/lstm_function_dot_acc.sv - streaming saturating dot-product accumulator with registered result
module lstm_function_dot_acc
    import lstm_function_pkg::*;
#(
    parameter int PROD_WIDTH = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  acc_clr,
    input  logic [PROD_WIDTH-1:0] in_prod,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf,
    output logic                  out_valid,
    input  logic                  out_ready
);

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;
    logic                 out_valid_q, out_valid_d;

    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;
    logic [CNT_WIDTH-1:0] cnt_inc;

    lstm_function_sat_add #(
        .A_WIDTH (ACC_WIDTH),
        .B_WIDTH (PROD_WIDTH)
    ) u_sat_add (
        .a_i   (acc_q),
        .b_i   (in_prod),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign cnt_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Ready is a pure function of state so out_ready never reaches in_ready.
    assign in_ready  = (state_q == ACC);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

    // Next-state: accumulate terms in ACC, hold the result in DONE until it is taken.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACC: begin
                if (acc_clr) begin
                    // Abort wins over a same-cycle term, which is dropped.
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (in_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_ovf;
                    if (in_last) begin
                        out_sum_d   = add_sum;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | add_ovf;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                // acc_clr is ignored here so a pending result is never lost.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial or pending result.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
